dgb_rect_engine: RTL
====================

DGB_RECT_ENGINE -- requirements
Module: dgb_rect_engine

Interface
REQ-001 The block SHALL take parameter pHdisplay, default 640: active pixels per line.
REQ-002 The block SHALL take parameter pVdisplay, default 480: active lines per frame.
REQ-003 The block SHALL take parameter pPixelWidth, default 24: RGB pixel width.
REQ-004 The block SHALL take parameter pRectNum, default 4, legal range 1..16: number of rectangle channels.
REQ-005 The block SHALL take parameter pBlinkFrames, default 60: frames per blink half-period.
REQ-006 The block SHALL take parameter pBgColor, default 0: background pixel value.
REQ-007 The block SHALL have port iBCLK, input, 1 bit: base clock.
REQ-008 The block SHALL have port iRST, input, 1 bit: reset, synchronous, active-high, sampled on iBCLK.
REQ-009 The block SHALL have port iCKE, input, 1 bit: pixel advance enable.
REQ-010 The block SHALL have port iWe, input, 1 bit: register write strobe.
REQ-011 The block SHALL have port iWidx, input, 4 bits: rectangle index.
REQ-012 The block SHALL have port iWreg, input, 3 bits: field select (0 x0, 1 x1, 2 y0, 3 y1, 4 color, 5 ctrl).
REQ-013 The block SHALL have port iWdata, input, 32 bits: write data, LSB-aligned.
REQ-014 The block SHALL have port oPixel, output, pPixelWidth bits: generated pixel.
REQ-015 The block SHALL have port oVd, output, 1 bit: oPixel valid.
REQ-016 The block SHALL have port oFe, output, 1 bit: one-cycle frame-end pulse.
REQ-017 The block SHALL have port oCommit, output, 1 bit: one-cycle pulse when shadow registers load into active registers.

Function
REQ-018 The raster counters SHALL be H (0..pHdisplay-1) and V (0..pVdisplay-1), with widths from the MSB-one bit-width rule.
REQ-019 H SHALL advance only on cycles where iCKE=1; it SHALL wrap to 0 and advance V; V SHALL wrap to 0 after pVdisplay-1.
REQ-020 oFe SHALL be 1 for exactly one cycle, registered, in the cycle after an iCKE=1 cycle at H=pHdisplay-1, V=pVdisplay-1.
REQ-021 Each rectangle SHALL have shadow and active copies of x0, x1, y0, y1 (counter widths), color (pPixelWidth), ctrl bit0 enable and ctrl bit1 blink; wider write data SHALL be truncated.
REQ-022 A write with iWe=1 SHALL update only the shadow field selected by iWidx/iWreg and SHALL set the dirty flag.
REQ-023 A write with iWidx>=pRectNum or iWreg>=6 SHALL be ignored and SHALL leave the dirty flag unchanged.
REQ-024 In the cycle oFe=1 with dirty=1, all active registers SHALL load the shadow copies, oCommit SHALL pulse in that same cycle, and dirty SHALL clear.
REQ-025 The active set SHALL never change mid-frame.
REQ-026 If a write coincides with the commit cycle, the active set SHALL take the pre-write shadow value, the write SHALL land in shadow, and dirty SHALL remain 1 so it commits at the next frame end.
REQ-027 A rectangle hit SHALL require enable=1, x0<=H<=x1 and y0<=V<=y1, all bounds inclusive.
REQ-028 A rectangle with x0>x1 or y0>y1 SHALL never hit.
REQ-029 A blink-enabled rectangle SHALL hit only while the blink phase is 0.
REQ-030 The blink counter SHALL count oFe pulses 0..pBlinkFrames-1; on wrap it SHALL return to 0 and toggle the blink phase.
REQ-031 Stage 1 SHALL register the per-rectangle hit vector plus a valid bit equal to iCKE.
REQ-032 Stage 2 SHALL register oPixel as the color of the lowest-index hitting rectangle, or pBgColor if none hits, and set oVd to the stage-1 valid bit.
REQ-033 The pixel for the counter position sampled at cycle t (iCKE=1) SHALL appear on oPixel with oVd=1 at cycle t+2.
REQ-034 oPixel SHALL hold its last value when oVd=0.

Reset
REQ-035 While iRST=1, H, V, the blink counter, the blink phase and dirty SHALL be 0, and oPixel, oVd, oFe and oCommit SHALL be 0.
REQ-036 While iRST=1, all shadow and active fields SHALL be 0, so every rectangle is disabled.
REQ-037 An iRST assertion mid-frame SHALL take effect on the next clock edge, discard pipeline contents and restart at H=0, V=0.

Verification
REQ-038 Reset, then iCKE=1 continuously for 640x480 cycles -> oFe pulses once at cycle 307200 (counting from the first iCKE), oPixel=pBgColor throughout, oCommit=0.
REQ-039 Rect0 set to x0=30, x1=100, y0=30, y1=100, color=0x4169E1, ctrl=1, then one frame -> next frame shows 0x4169E1 at (30,30), (100,100) and (65,65), and background at (29,30), (101,100) and (30,101).
REQ-040 Rect0 and rect1 overlapping, colors 0xFF0000 and 0x00FF00 -> the overlap region shows 0xFF0000.
REQ-041 Rect0 moved by a write mid-frame -> the current frame is unchanged, oCommit pulses with oFe, and the new position appears from the next frame.
REQ-042 Rect0 with ctrl=3 and pBlinkFrames=2 -> the rectangle is visible in frames 0-1, hidden in frames 2-3, and visible in frames 4-5.
REQ-043 Write with iWidx=pRectNum, plus iCKE toggled 1,0,1 -> no commit occurs, and oVd reproduces 1,0,1 two cycles later.

Source files
------------

// File: rtl/dgb_rect_engine.sv
// Purpose : raster rectangle overlay; draws up to pRectNum coloured, optionally blinking boxes over a background.
// Latency : 2 cycles from an iCKE=1 raster position to its oPixel/oVd.
// Backpr. : none; iCKE gates raster advance, oVd mirrors iCKE two cycles later, oPixel holds while oVd=0.
// Ports   : iBCLK/iRST clock and sync active-high reset; iCKE pixel advance;
//           iWe/iWidx/iWreg/iWdata shadow register write (fields: 0 x0, 1 x1, 2 y0, 3 y1, 4 color, 5 ctrl);
//           oPixel/oVd generated pixel; oFe frame-end pulse; oCommit shadow->active load pulse.
module dgb_rect_engine #(
    parameter int pHdisplay    = 640,
    parameter int pVdisplay    = 480,
    parameter int pPixelWidth  = 24,
    parameter int pRectNum     = 4,
    parameter int pBlinkFrames = 60,
    parameter logic [pPixelWidth-1:0] pBgColor = '0
) (
    input  logic                   iBCLK,
    input  logic                   iRST,
    input  logic                   iCKE,
    input  logic                   iWe,
    input  logic [3:0]             iWidx,
    input  logic [2:0]             iWreg,
    input  logic [31:0]            iWdata,
    output logic [pPixelWidth-1:0] oPixel,
    output logic                   oVd,
    output logic                   oFe,
    output logic                   oCommit
);

    localparam int HW = (pHdisplay > 1) ? $clog2(pHdisplay) : 1;
    localparam int VW = (pVdisplay > 1) ? $clog2(pVdisplay) : 1;
    localparam int BW = (pBlinkFrames > 1) ? $clog2(pBlinkFrames) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(pHdisplay - 1);
    localparam logic [VW-1:0] V_LAST = VW'(pVdisplay - 1);
    localparam logic [BW-1:0] B_LAST = BW'(pBlinkFrames - 1);
    localparam logic [4:0]    RECT_NUM = 5'(pRectNum);

    typedef struct packed {
        logic [HW-1:0]          x0;
        logic [HW-1:0]          x1;
        logic [VW-1:0]          y0;
        logic [VW-1:0]          y1;
        logic [pPixelWidth-1:0] color;
        logic                   en;
        logic                   blink;
    } rect_t;

    logic [HW-1:0]          h_q, h_d;
    logic [VW-1:0]          v_q, v_d;
    logic                   fe_q, fe_d;
    logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                   blink_ph_q, blink_ph_d;
    logic                   dirty_q, dirty_d;
    rect_t                  sh_q  [pRectNum];
    rect_t                  sh_d  [pRectNum];
    rect_t                  act_q [pRectNum];
    rect_t                  act_d [pRectNum];
    logic [pRectNum-1:0]    hit_q, hit_d;
    logic                   s1_vld_q;
    logic [pPixelWidth-1:0] pixel_q, pix_d;
    logic                   vd_q;
    logic                   wr_ok;
    logic                   commit;
    logic                   wdata_unused;

    // Upper write-data bits are truncated away by design.
    assign wdata_unused = ^iWdata;

    assign wr_ok  = iWe && ({1'b0, iWidx} < RECT_NUM) && (iWreg < 3'd6);
    assign commit = fe_q && dirty_q;

    // Raster counters and registered frame-end detect.
    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        fe_d = iCKE && (h_q == H_LAST) && (v_q == V_LAST);
        if (iCKE) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Blink phase flips every pBlinkFrames frame ends.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (fe_q) begin
            if (blink_cnt_q == B_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Shadow writes; the active set copies the pre-write shadow on commit.
    always_comb begin
        for (int i = 0; i < pRectNum; i++) begin
            sh_d[i]  = sh_q[i];
            act_d[i] = commit ? sh_q[i] : act_q[i];
            if (wr_ok && (iWidx == 4'(i))) begin
                case (iWreg)
                    3'd0: sh_d[i].x0    = iWdata[HW-1:0];
                    3'd1: sh_d[i].x1    = iWdata[HW-1:0];
                    3'd2: sh_d[i].y0    = iWdata[VW-1:0];
                    3'd3: sh_d[i].y1    = iWdata[VW-1:0];
                    3'd4: sh_d[i].color = iWdata[pPixelWidth-1:0];
                    3'd5: begin
                        sh_d[i].en    = iWdata[0];
                        sh_d[i].blink = iWdata[1];
                    end
                    default: ;
                endcase
            end
        end
        dirty_d = commit ? wr_ok : (dirty_q || wr_ok);
    end

    // The oFe cycle is already the first cycle of the new frame (H=0,V=0), so
    // hits use the next-state active set and blink phase; outside that cycle
    // they equal the current state, keeping every frame on one consistent set.
    always_comb begin
        for (int i = 0; i < pRectNum; i++) begin
            hit_d[i] = act_d[i].en && !(act_d[i].blink && blink_ph_d) &&
                       (act_d[i].x0 <= h_q) && (h_q <= act_d[i].x1) &&
                       (act_d[i].y0 <= v_q) && (v_q <= act_d[i].y1);
        end
    end

    // Lowest index wins: scan downward so index 0 is applied last.
    always_comb begin
        pix_d = pBgColor;
        for (int i = pRectNum - 1; i >= 0; i--) begin
            if (hit_q[i]) pix_d = act_q[i].color;
        end
    end

    always_ff @(posedge iBCLK) begin
        if (iRST) begin
            h_q         <= '0;
            v_q         <= '0;
            fe_q        <= 1'b0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            dirty_q     <= 1'b0;
            hit_q       <= '0;
            s1_vld_q    <= 1'b0;
            pixel_q     <= '0;
            vd_q        <= 1'b0;
            for (int i = 0; i < pRectNum; i++) begin
                sh_q[i]  <= '0;
                act_q[i] <= '0;
            end
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            fe_q        <= fe_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            dirty_q     <= dirty_d;
            hit_q       <= hit_d;
            s1_vld_q    <= iCKE;
            vd_q        <= s1_vld_q;
            if (s1_vld_q) pixel_q <= pix_d;
            for (int i = 0; i < pRectNum; i++) begin
                sh_q[i]  <= sh_d[i];
                act_q[i] <= act_d[i];
            end
        end
    end

    assign oPixel  = pixel_q;
    assign oVd     = vd_q;
    assign oFe     = fe_q;
    assign oCommit = commit;

endmodule
